// File: rtl/decode_regfile_if.sv
// Decode-stage bus: fetch-side instruction, pipeline control, write-back port
// and the registered ID/EX outputs.
interface decode_regfile_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            instr_valid;
    logic [31:0]     instruction;
    logic            stall;
    logic            flush;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;

    logic            out_valid;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic            out_illegal;

    modport master (
        output instr_valid, instruction, stall, flush, wb_en, wb_addr, wb_data,
        input  out_valid, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
               out_funct7, out_imm, out_rs1_data, out_rs2_data, out_illegal
    );

    modport slave (
        input  instr_valid, instruction, stall, flush, wb_en, wb_addr, wb_data,
        output out_valid, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
               out_funct7, out_imm, out_rs1_data, out_rs2_data, out_illegal
    );
endinterface

// File: rtl/decode_regfile_stage.sv
// RV32 decode stage: field/immediate decode, register file with write-back
// forwarding, and a registered ID/EX output supporting stall and flush.
module decode_regfile_stage #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter bit BYPASS    = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    decode_regfile_if.slave bus
);
    localparam int AW = $clog2(REG_COUNT);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_BAD = 3'd6
    } fmt_e;

    typedef struct packed {
        logic            valid;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic            illegal;
    } stage_t;

    logic [REG_COUNT-1:0][XLEN-1:0] regs_q;
    logic [REG_COUNT-1:0][XLEN-1:0] regs_d;
    stage_t                         stage_q;
    stage_t                         stage_d;

    logic [31:0]     ins_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;
    fmt_e            fmt_s;
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] imm_s;
    logic            uses_rd_s;
    logic            uses_rs1_s;
    logic            uses_rs2_s;
    logic            illegal_s;
    logic            wb_live_s;
    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;

    // Index exists in this register file (RV32E has only x0..x15).
    function automatic logic idx_ok(input logic [4:0] idx);
        return (idx >> AW) == 5'd0;
    endfunction

    function automatic logic wb_hits(input logic live, input logic [AW-1:0] waddr,
                                     input logic [4:0] idx);
        return live && (5'(waddr) == idx);
    endfunction

    assign ins_s     = bus.instruction;
    assign rs1_s     = ins_s[19:15];
    assign rs2_s     = ins_s[24:20];
    assign rd_s      = ins_s[11:7];
    assign wb_live_s = bus.wb_en && (bus.wb_addr != {AW{1'b0}});
    assign imm_s     = XLEN'($signed(imm32_s));

    // Instruction format classification and which register fields it uses.
    always_comb begin
        fmt_s      = FMT_BAD;
        uses_rd_s  = 1'b0;
        uses_rs1_s = 1'b0;
        uses_rs2_s = 1'b0;
        case (ins_s[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                fmt_s = FMT_I; uses_rd_s = 1'b1; uses_rs1_s = 1'b1;
            end
            OPC_STORE:  begin fmt_s = FMT_S; uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            OPC_BRANCH: begin fmt_s = FMT_B; uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            OPC_LUI, OPC_AUIPC: begin fmt_s = FMT_U; uses_rd_s = 1'b1; end
            OPC_JAL:    begin fmt_s = FMT_J; uses_rd_s = 1'b1; end
            OPC_OP: begin
                fmt_s = FMT_R; uses_rd_s = 1'b1; uses_rs1_s = 1'b1; uses_rs2_s = 1'b1;
            end
            default:    fmt_s = FMT_BAD;
        endcase
    end

    // Immediate assembly, sign bit always taken from instruction bit 31.
    always_comb begin
        imm32_s = 32'd0;
        case (fmt_s)
            FMT_I:   imm32_s = {{20{ins_s[31]}}, ins_s[31:20]};
            FMT_S:   imm32_s = {{20{ins_s[31]}}, ins_s[31:25], ins_s[11:7]};
            FMT_B:   imm32_s = {{19{ins_s[31]}}, ins_s[31], ins_s[7], ins_s[30:25],
                                ins_s[11:8], 1'b0};
            FMT_U:   imm32_s = {ins_s[31:12], 12'd0};
            FMT_J:   imm32_s = {{11{ins_s[31]}}, ins_s[31], ins_s[19:12], ins_s[20],
                                ins_s[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
    end

    assign illegal_s = (fmt_s == FMT_BAD)
                     || (uses_rd_s  && !idx_ok(rd_s))
                     || (uses_rs1_s && !idx_ok(rs1_s))
                     || (uses_rs2_s && !idx_ok(rs2_s));

    // Operand read; a write landing on the same edge is forwarded when enabled.
    always_comb begin
        rs1_val_s = {XLEN{1'b0}};
        rs2_val_s = {XLEN{1'b0}};
        if (BYPASS && wb_hits(wb_live_s, bus.wb_addr, rs1_s)) rs1_val_s = bus.wb_data;
        else if (idx_ok(rs1_s)) rs1_val_s = regs_q[rs1_s[AW-1:0]];
        else rs1_val_s = {XLEN{1'b0}};
        if (BYPASS && wb_hits(wb_live_s, bus.wb_addr, rs2_s)) rs2_val_s = bus.wb_data;
        else if (idx_ok(rs2_s)) rs2_val_s = regs_q[rs2_s[AW-1:0]];
        else rs2_val_s = {XLEN{1'b0}};
    end

    // Register file write; x0 is never written so it always reads zero.
    always_comb begin
        regs_d = regs_q;
        if (wb_live_s) regs_d[bus.wb_addr] = bus.wb_data;
        else regs_d = regs_q;
    end

    // Output stage: flush beats stall beats accept; stalled operands track write-back.
    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d.valid = 1'b0;
        end else if (bus.stall) begin
            if (wb_hits(wb_live_s, bus.wb_addr, stage_q.rs1)) stage_d.rs1_data = bus.wb_data;
            else stage_d.rs1_data = stage_q.rs1_data;
            if (wb_hits(wb_live_s, bus.wb_addr, stage_q.rs2)) stage_d.rs2_data = bus.wb_data;
            else stage_d.rs2_data = stage_q.rs2_data;
        end else if (bus.instr_valid) begin
            stage_d.valid    = 1'b1;
            stage_d.opcode   = ins_s[6:0];
            stage_d.rd       = rd_s;
            stage_d.rs1      = rs1_s;
            stage_d.rs2      = rs2_s;
            stage_d.funct3   = ins_s[14:12];
            stage_d.funct7   = ins_s[31:25];
            stage_d.imm      = imm_s;
            stage_d.rs1_data = rs1_val_s;
            stage_d.rs2_data = rs2_val_s;
            stage_d.illegal  = illegal_s;
        end else begin
            stage_d.valid = 1'b0;
        end
    end

    // Register file state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) regs_q <= '0;
        else regs_q <= regs_d;
    end

    // ID/EX output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stage_q <= '0;
        else stage_q <= stage_d;
    end

    assign bus.out_valid    = stage_q.valid;
    assign bus.out_opcode   = stage_q.opcode;
    assign bus.out_rd       = stage_q.rd;
    assign bus.out_rs1      = stage_q.rs1;
    assign bus.out_rs2      = stage_q.rs2;
    assign bus.out_funct3   = stage_q.funct3;
    assign bus.out_funct7   = stage_q.funct7;
    assign bus.out_imm      = stage_q.imm;
    assign bus.out_rs1_data = stage_q.rs1_data;
    assign bus.out_rs2_data = stage_q.rs2_data;
    assign bus.out_illegal  = stage_q.illegal;
endmodule

// File: tb/tb_decode_regfile_stage.sv
// Scoreboard bench for decode_regfile_stage: three configurations (default,
// no bypass, RV32E) driven with the same directed instruction stream.
module tb_decode_regfile_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_regfile_if #(.XLEN(32), .AW(5)) ia ();
    decode_regfile_if #(.XLEN(32), .AW(5)) ib ();
    decode_regfile_if #(.XLEN(32), .AW(4)) ic ();

    decode_regfile_stage #(.XLEN(32), .REG_COUNT(32), .BYPASS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(ia.slave));
    decode_regfile_stage #(.XLEN(32), .REG_COUNT(32), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(ib.slave));
    decode_regfile_stage #(.XLEN(32), .REG_COUNT(16), .BYPASS(1'b1)) dut_c (
        .clk(clk), .reset(reset), .bus(ic.slave));

    typedef struct {
        logic [31:0] ins;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        ill;
        bit          care;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] imm,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic ill, input bit care);
        exp_t e;
        e.ins = ins; e.imm = imm; e.d1 = d1; e.d2 = d2; e.ill = ill; e.care = care;
        return e;
    endfunction

    task automatic push(input logic [31:0] ins, input logic [31:0] imm,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic ill, input bit cb, input bit cc);
        qa.push_back(mk(ins, imm, d1, d2, ill, 1'b1));
        qb.push_back(mk(ins, imm, d1, d2, ill, cb));
        qc.push_back(mk(ins, imm, d1, d2, ill, cc));
    endtask

    task automatic cmp_out(input string t, input exp_t e, input logic [6:0] op,
                           input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm, input logic [31:0] d1,
                           input logic [31:0] d2, input logic ill);
        chk({t, "_opcode"}, 32'(op), 32'(e.ins[6:0]));
        chk({t, "_rd"},     32'(rd), 32'(e.ins[11:7]));
        chk({t, "_rs1"},    32'(r1), 32'(e.ins[19:15]));
        chk({t, "_rs2"},    32'(r2), 32'(e.ins[24:20]));
        chk({t, "_funct3"}, 32'(f3), 32'(e.ins[14:12]));
        chk({t, "_funct7"}, 32'(f7), 32'(e.ins[31:25]));
        chk({t, "_imm"},    imm, e.imm);
        chk({t, "_rs1_data"}, d1, e.d1);
        chk({t, "_rs2_data"}, d2, e.d2);
        chk({t, "_illegal"},  32'(ill), 32'(e.ill));
    endtask

    // Monitor: every cycle a DUT shows out_valid, pop its expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ia.out_valid === 1'b1) begin
                if (qa.size() == 0) chk("a_unexpected_valid", 32'd1, 32'd0);
                else begin
                    e = qa.pop_front();
                    cmp_out("a", e, ia.out_opcode, ia.out_rd, ia.out_rs1, ia.out_rs2,
                            ia.out_funct3, ia.out_funct7, ia.out_imm, ia.out_rs1_data,
                            ia.out_rs2_data, ia.out_illegal);
                end
            end
            if (ib.out_valid === 1'b1) begin
                if (qb.size() == 0) chk("b_unexpected_valid", 32'd1, 32'd0);
                else begin
                    e = qb.pop_front();
                    if (e.care)
                        cmp_out("b", e, ib.out_opcode, ib.out_rd, ib.out_rs1, ib.out_rs2,
                                ib.out_funct3, ib.out_funct7, ib.out_imm, ib.out_rs1_data,
                                ib.out_rs2_data, ib.out_illegal);
                end
            end
            if (ic.out_valid === 1'b1) begin
                if (qc.size() == 0) chk("c_unexpected_valid", 32'd1, 32'd0);
                else begin
                    e = qc.pop_front();
                    if (e.care)
                        cmp_out("c", e, ic.out_opcode, ic.out_rd, ic.out_rs1, ic.out_rs2,
                                ic.out_funct3, ic.out_funct7, ic.out_imm, ic.out_rs1_data,
                                ic.out_rs2_data, ic.out_illegal);
                end
            end
        end
    end

    task automatic set_in(input logic v, input logic [31:0] ins, input logic st,
                          input logic fl, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd);
        ia.instr_valid = v; ia.instruction = ins; ia.stall = st; ia.flush = fl;
        ia.wb_en = we; ia.wb_addr = wa; ia.wb_data = wd;
        ib.instr_valid = v; ib.instruction = ins; ib.stall = st; ib.flush = fl;
        ib.wb_en = we; ib.wb_addr = wa; ib.wb_data = wd;
        ic.instr_valid = v; ic.instruction = ins; ic.stall = st; ic.flush = fl;
        ic.wb_en = we && (wa < 5'd16); ic.wb_addr = wa[3:0]; ic.wb_data = wd;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic st,
                         input logic fl, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        set_in(v, ins, st, fl, we, wa, wd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(ia.out_valid), 32'd0);
        chk("reset_imm", ia.out_imm, 32'd0);
        reset = 1'b0;

        // Async reset mid-cycle clears outputs and register file.
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA5A5A5A5);
        push(32'h00128393, 32'd1, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h00128393, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midreset_valid", 32'(ia.out_valid), 32'd0);
        chk("midreset_rd", 32'(ia.out_rd), 32'd0);
        chk("midreset_imm", ia.out_imm, 32'd0);
        chk("midreset_rs1_data", ia.out_rs1_data, 32'd0);
        chk("midreset_opcode", 32'(ia.out_opcode), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        push(32'h00028413, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h00028413, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // x0 writes are dropped, and never forwarded.
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
        push(32'hFFF00093, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'hFFF00093, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);

        // Immediate formats: S, B, U, J.
        push(32'hFE20AE23, 32'hFFFFFFFC, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'hFE20AE23, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        push(32'hFE000CE3, 32'hFFFFFFF8, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'hFE000CE3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        push(32'h123452B7, 32'h12345000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h123452B7, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        push(32'h801FF06F, 32'hFFFFF800, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h801FF06F, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Bypass: add x4,x3,x3 with same-cycle write of x3; b sees the old value.
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h00001111);
        push(32'h00318233, 32'd0, 32'h00001234, 32'h00001234, 1'b0, 1'b0, 1'b1);
        void'(qb.pop_back());
        qb.push_back(mk(32'h00318233, 32'd0, 32'h00001111, 32'h00001111, 1'b0, 1'b1));
        drive(1'b1, 32'h00318233, 1'b0, 1'b0, 1'b1, 5'd3, 32'h00001234);
        push(32'h00318233, 32'd0, 32'h00001234, 32'h00001234, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h00318233, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Stall: held rs1 operand follows write-back of x3; then stall+flush.
        push(32'h00518493, 32'd5, 32'h00001234, 32'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h00518493, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        push(32'h00518493, 32'd5, 32'h00000055, 32'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h0000007F, 1'b1, 1'b0, 1'b1, 5'd3, 32'h00000055);
        push(32'h00518493, 32'd5, 32'h00000055, 32'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h0000007F, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        push(32'h00518493, 32'd5, 32'h00000055, 32'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h0000007F, 1'b1, 1'b0, 1'b1, 5'd7, 32'h00000077);
        drive(1'b1, 32'h0000007F, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("flush_valid_a", 32'(ia.out_valid), 32'd0);
        chk("flush_valid_b", 32'(ib.out_valid), 32'd0);
        chk("flush_valid_c", 32'(ic.out_valid), 32'd0);
        push(32'h00318233, 32'd0, 32'h00000055, 32'h00000055, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h00318233, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("bubble_valid", 32'(ia.out_valid), 32'd0);
        chk("bubble_hold_rs1_data", ia.out_rs1_data, 32'h00000055);
        chk("bubble_hold_rd", 32'(ia.out_rd), 32'd4);

        // Illegal opcode, and RV32E out-of-range rs1.
        push(32'h0000007F, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 32'h0000007F, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd17, 32'h0000DEAD);
        push(32'h00088093, 32'd0, 32'h0000DEAD, 32'd0, 1'b0, 1'b1, 1'b0);
        void'(qc.pop_back());
        qc.push_back(mk(32'h00088093, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1));
        drive(1'b1, 32'h00088093, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        repeat (3) drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        chk("c_queue_drained", 32'(qc.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
